// File: rtl/spi_frame_sched.sv
// Round-robin scheduler sharing one SPI frame engine between NUM_REQ requesters.
// Optional WAIT_DONE timeout with engine abort: define SPI_SCHED_TIMEOUT_EN.
module spi_frame_sched #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 24,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      rsp_valid,
  output logic [2:0]                rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      eng_start,
  output logic [DATA_W-1:0]         eng_tx_data,
  output logic                      eng_abort,
  input  logic                      eng_done,
  input  logic [DATA_W-1:0]         eng_rx_data,
  input  logic                      eng_crc_err,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_RESP,
    S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    cur_id_q, cur_id_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                eng_start_q, eng_start_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [2:0]          rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic [DATA_W-1:0]   sel_data;
  logic [IDX_W:0]      cand;
  logic [IDX_W:0]      ptr_nxt;

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                abort_q, abort_d;
`endif

  // First pending requester at or above rr_ptr, wrapping past NUM_REQ-1.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!sel_found && req[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == sel_idx) sel_data = req_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_id_d    = cur_id_q;
    tx_data_d   = tx_data_q;
    grant_d     = '0;
    eng_start_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    gap_cnt_d   = gap_cnt_q;
    ptr_nxt     = {1'b0, cur_id_q} + (IDX_W+1)'(1);
`ifdef SPI_SCHED_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    abort_d     = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          cur_id_d         = sel_idx;
          tx_data_d        = sel_data;
          grant_d[sel_idx] = 1'b1;
          eng_start_d      = 1'b1;
          state_d          = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        rr_ptr_d = (ptr_nxt == (IDX_W+1)'(NUM_REQ)) ? '0 : ptr_nxt[IDX_W-1:0];
`ifdef SPI_SCHED_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        state_d  = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // eng_done takes priority over a timeout reached on the same cycle.
        if (eng_done) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = 3'(cur_id_q);
          rsp_data_d  = eng_rx_data;
          rsp_err_d   = eng_crc_err;
          state_d     = S_RESP;
        end
`ifdef SPI_SCHED_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          abort_d     = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_id_d    = 3'(cur_id_q);
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      S_RESP: begin
        gap_cnt_d = '0;
        state_d   = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      tx_data_q   <= '0;
      grant_q     <= '0;
      eng_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_id_q    <= cur_id_d;
      tx_data_q   <= tx_data_d;
      grant_q     <= grant_d;
      eng_start_q <= eng_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

`ifdef SPI_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo_cnt_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      abort_q   <= abort_d;
    end
  end
  assign eng_abort = abort_q;
`else
  assign eng_abort = 1'b0;
`endif

  assign grant       = grant_q;
  assign eng_start   = eng_start_q;
  assign eng_tx_data = tx_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_frame_sched.sv
// Directed bench for spi_frame_sched: hand-computed grants, responses, gaps and reset.
module tb_spi_frame_sched;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 24;
  localparam int GAP_CYC = 4;
  localparam int TMO_CYC = 16;

  logic                      clk = 1'b0;
  logic                      rstn;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      rsp_valid;
  logic [2:0]                rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      eng_start;
  logic [DATA_W-1:0]         eng_tx_data;
  logic                      eng_abort;
  logic                      eng_done;
  logic [DATA_W-1:0]         eng_rx_data;
  logic                      eng_crc_err;
  logic                      busy;

  int vectors     = 0;
  int miscompares = 0;

  spi_frame_sched #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TMO_CYC)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_data(req_data), .grant(grant),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_tx_data(eng_tx_data), .eng_abort(eng_abort),
    .eng_done(eng_done), .eng_rx_data(eng_rx_data), .eng_crc_err(eng_crc_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Waits (bounded) for a grant; n is the number of cycles elapsed.
  task automatic wait_grant(input logic [3:0] exp, input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (grant == '0 && n < 60);
    check({tag, "_grant"}, 32'(grant), 32'(exp));
    check({tag, "_start"}, 32'(eng_start), 32'd1);
  endtask

  task automatic engine_done(input logic [23:0] rx, input logic err,
                             input logic [2:0] exp_id, input string tag);
    eng_done    = 1'b1;
    eng_rx_data = rx;
    eng_crc_err = err;
    tick();
    eng_done = 1'b0;
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"},    32'(rsp_id),    32'(exp_id));
    check({tag, "_data"},  32'(rsp_data),  32'(rx));
    check({tag, "_err"},   32'(rsp_err),   32'(err));
    check({tag, "_abort"}, 32'(eng_abort), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_rv"},    32'(rsp_valid), 32'd0);
    check({tag, "_rid"},   32'(rsp_id), 32'd0);
    check({tag, "_rdata"}, 32'(rsp_data), 32'd0);
    check({tag, "_rerr"},  32'(rsp_err), 32'd0);
    check({tag, "_start"}, 32'(eng_start), 32'd0);
    check({tag, "_tx"},    32'(eng_tx_data), 32'd0);
    check({tag, "_abort"}, 32'(eng_abort), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int seen;
    int seen2;
    logic [3:0] exp_g;
    logic [23:0] d [4];

    rstn = 1'b0; req = '0; req_data = '0;
    eng_done = 1'b0; eng_rx_data = '0; eng_crc_err = 1'b0;
    wait_cycles(2);
    check_all_zero("rst0");
    rstn = 1'b1;

    // Single frame: grant/start exactly one cycle after req is sampled.
    req_data[23:0] = 24'hA5A5A5;
    req = 4'b0001;
    tick();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_start", 32'(eng_start), 32'd1);
    check("t1_tx",    32'(eng_tx_data), 32'hA5A5A5);
    check("t1_busy",  32'(busy), 32'd1);
    req = 4'b0000;
    tick();
    check("t1_grant_off", 32'(grant), 32'd0);
    check("t1_start_off", 32'(eng_start), 32'd0);
    wait_cycles(38);
    engine_done(24'h123456, 1'b0, 3'd0, "t1_rsp");
    tick();
    check("t1_valid_off", 32'(rsp_valid), 32'd0);
    check("t1_tx_hold",   32'(eng_tx_data), 32'hA5A5A5);

    // All requesters held: 0,1,2,3,0 with done-to-start spacing of GAP_CYC+3.
    rstn = 1'b0; tick(); rstn = 1'b1;
    d[0] = 24'hAA0000; d[1] = 24'hBB0001; d[2] = 24'hCC0002; d[3] = 24'hDD0003;
    req_data = {d[3], d[2], d[1], d[0]};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      wait_grant(exp_g, "rr", n);
      if (i > 0) check("rr_spacing", 32'(n + 1), 32'(GAP_CYC + 3));
      check("rr_tx", 32'(eng_tx_data), 32'(d[i % 4]));
      wait_cycles(5);
      engine_done(24'hC00000 | 24'(i), 1'b0, 3'(i % 4), "rr_rsp");
    end

    // rr_ptr=1 with req 0101: 2 first, with a CRC error response, then 0.
    req = 4'b0101;
    wait_grant(4'b0100, "p1", n);
    check("p1_tx", 32'(eng_tx_data), 32'hCC0002);
    req = 4'b0001;
    wait_cycles(3);
    engine_done(24'hFFFFFF, 1'b1, 3'd2, "crc");
    wait_grant(4'b0001, "p0", n);
    check("p0_tx", 32'(eng_tx_data), 32'hAA0000);
    req = 4'b1001;
    wait_cycles(3);
    engine_done(24'h654321, 1'b0, 3'd0, "p0_rsp");
    wait_grant(4'b1000, "p3", n);
    check("p3_tx", 32'(eng_tx_data), 32'hDD0003);
    // Requester 0 withdraws while 3 is being served.
    req = 4'b0000;
    wait_cycles(3);
    engine_done(24'h0F0F0F, 1'b0, 3'd3, "p3_rsp");
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (grant != '0) seen++;
    end
    check("wd_no_grant", 32'(seen), 32'd0);
    check("wd_idle", 32'(busy), 32'd0);

`ifdef SPI_SCHED_TIMEOUT_EN
    // No eng_done: abort and error response 16 cycles after WAIT_DONE entry.
    req = 4'b0100;
    wait_grant(4'b0100, "to", n);
    req = 4'b0000;
    seen = 0; seen2 = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (eng_abort) seen++;
      if (rsp_valid) seen2++;
    end
    check("to_early_abort", 32'(seen), 32'd0);
    check("to_early_rsp",   32'(seen2), 32'd0);
    tick();
    check("to_abort", 32'(eng_abort), 32'd1);
    check("to_valid", 32'(rsp_valid), 32'd1);
    check("to_err",   32'(rsp_err), 32'd1);
    check("to_data",  32'(rsp_data), 32'd0);
    check("to_id",    32'(rsp_id), 32'd2);
    tick();
    check("to_abort_off", 32'(eng_abort), 32'd0);
    // eng_done on the terminal cycle wins over the timeout.
    req = 4'b0100;
    wait_grant(4'b0100, "tt", n);
    req = 4'b0000;
    wait_cycles(16);
    engine_done(24'h5A5A5A, 1'b0, 3'd2, "tt_rsp");
`else
    // Without the timeout the block waits indefinitely for eng_done.
    req = 4'b0100;
    wait_grant(4'b0100, "nt", n);
    req = 4'b0000;
    seen = 0; seen2 = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (eng_abort) seen++;
      if (rsp_valid) seen2++;
    end
    check("nt_abort", 32'(seen), 32'd0);
    check("nt_rsp",   32'(seen2), 32'd0);
    check("nt_busy",  32'(busy), 32'd1);
    engine_done(24'h5A5A5A, 1'b0, 3'd2, "nt_rsp");
`endif

    // Reset during WAIT_DONE abandons the frame and clears rr_ptr.
    wait_cycles(8);
    req = 4'b0100;
    wait_grant(4'b0100, "mr", n);
    req = 4'b0000;
    wait_cycles(3);
    rstn = 1'b0;
    tick();
    check_all_zero("mr_rst");
    rstn = 1'b1;
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("mr_no_rsp", 32'(rsp_valid), 32'd0);
    tick();
    check("mr_no_rsp2", 32'(rsp_valid), 32'd0);
    check("mr_idle",    32'(busy), 32'd0);
    req = 4'b1010;
    wait_grant(4'b0010, "mr_first", n);
    check("mr_tx", 32'(eng_tx_data), 32'hBB0001);
    req = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_frame_sched.md
# spi_frame_sched

Round-robin scheduler that shares the single SPI frame engine (24-bit payload plus CRC-8 SAE-J1850 trailer, 32 SCK per frame) between up to NUM_REQ on-chip requesters. It sits between the requesters and the SPI master in the same clock domain. It serialises their frame requests, pulses the engine's start, waits for completion and routes the received 24-bit word and CRC status back to the owning requester. It also enforces a minimum chip-select-high gap between consecutive frames.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 24, payload width per frame
- GAP_CYC, 4, idle clk cycles enforced between engine done and next start (≥1)
- TIMEOUT_CYC, 1024, clk cycles allowed in WAIT_DONE (used only with SPI_SCHED_TIMEOUT_EN)
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- req  in  NUM_REQ  per-requester frame request, level
- req_data  in  NUM_REQ*DATA_W  tx payload; requester i owns bits [i*DATA_W +: DATA_W]
- grant  out  NUM_REQ  one-hot, one-cycle acceptance pulse
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  3  index of requester the response belongs to
- rsp_data  out  DATA_W  received payload
- rsp_err  out  1  CRC mismatch or timeout
- eng_start  out  1  one-cycle start pulse to engine
- eng_tx_data  out  DATA_W  payload to engine, stable from eng_start to eng_done
- eng_abort  out  1  one-cycle abort pulse (timeout only)
- eng_done  in  1  engine frame-complete pulse
- eng_rx_data  in  DATA_W  engine rx payload, valid with eng_done
- eng_crc_err  in  1  engine CRC check result, valid with eng_done
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LAUNCH, WAIT_DONE, RESP, GAP.
- IDLE: if any req bit is high, select the first set bit searching upward from rr_ptr, with wrap. Capture its req_data into eng_tx_data and its index into cur_id. Go to LAUNCH. If no req bit is high, stay in IDLE.
- LAUNCH (1 cycle):
  - grant[cur_id]=1 and eng_start=1.
  - rr_ptr <= (cur_id+1) mod NUM_REQ.
  - Go to WAIT_DONE.
- WAIT_DONE: on eng_done=1, latch eng_rx_data and eng_crc_err, then go to RESP. eng_done in any other state is ignored.
- RESP (1 cycle): rsp_valid=1 with rsp_id=cur_id, rsp_data=latched rx, rsp_err=latched crc_err. There is no backpressure. Go to GAP.
- GAP: count GAP_CYC cycles, then go to IDLE.
- Requester rules:
  - Hold req and req_data stable until grant.
  - Deassert req the cycle after grant unless another frame is wanted.
  - req dropped before grant is a withdrawal; that requester is not granted.
- Back-to-back requests from one requester are served only after every other pending requester has had one frame (fairness).
- eng_tx_data holds its value until the next capture in IDLE.

## Timing
- req sampled high in IDLE at cycle T: grant and eng_start are high at T+1, WAIT_DONE begins at T+2.
- eng_done sampled at cycle D: rsp_valid at D+1. The next eng_start is no earlier than D+GAP_CYC+3.
- Outputs are registered and change only on the clk rising edge.
- Reset (rstn=0 at a clk edge), from any state including mid-frame:
  - State goes to IDLE; rr_ptr=0.
  - grant, rsp_valid, rsp_id, rsp_data, rsp_err, eng_start, eng_tx_data, eng_abort and busy are all 0.
  - Any in-flight frame is abandoned with no response. The engine resets via its own rstn.
- eng_done coinciding with the timeout terminal count: done wins, a normal response is issued and there is no abort.

## Configuration
- SPI_SCHED_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT_DONE and clears on entry.
  - If TIMEOUT_CYC cycles elapse without eng_done, eng_abort pulses for 1 cycle and the block goes to RESP.
  - That response has rsp_data=0 and rsp_err=1.
- SPI_SCHED_TIMEOUT_EN undefined: no counter, eng_abort tied to 0, and WAIT_DONE waits indefinitely.

## Test plan
- Reset, then req=4'b0001 with data0=24'hA5A5A5 -> grant=0001 and eng_start at T+1 with eng_tx_data=A5A5A5. Model eng_done after 40 cycles with rx=24'h123456, crc_err=0 -> rsp_valid next cycle with rsp_id=0, rsp_data=123456, rsp_err=0.
- req=4'b1111 held continuously -> grant order 0,1,2,3,0; each consecutive eng_start separated by ≥ engine latency + GAP_CYC + 3 cycles.
- req=4'b0101 with rr_ptr=1 -> requester 2 granted first, then 0. Requester 0 withdraws (req[0]=0) before its grant -> no grant[0], block returns to IDLE.
- eng_done with eng_crc_err=1, rx=24'hFFFFFF -> rsp_err=1, rsp_data=FFFFFF, correct rsp_id.
- SPI_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, no eng_done -> eng_abort pulse 16 cycles after WAIT_DONE entry, then rsp_valid with rsp_err=1, rsp_data=0. Second case: eng_done on the terminal cycle -> normal response, no abort.
- rstn=0 for one cycle during WAIT_DONE -> all outputs 0 next cycle, no rsp_valid. A later req=4'b0010 is granted as the first grant after reset.
